// File: rtl/dlx_pipe_pkg.sv
// rtl/dlx_pipe_pkg.sv - shared FSM and forwarding encodings for the DLX pipeline interlock
package dlx_pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_LDSTALL = 2'b01,
    ST_FREEZE  = 2'b10
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [4:0] REG_R0 = 5'd0;

endpackage

// File: rtl/dlx_fwd_sel.sv
// rtl/dlx_fwd_sel.sv - EX operand forwarding select for one source register
module dlx_fwd_sel
  import dlx_pipe_pkg::*;
#(
  parameter int NREG_BITS = 5,
  parameter int FWD_BITS  = 2
) (
  input  logic [NREG_BITS-1:0] ex_src,
  input  logic [NREG_BITS-1:0] mem_rd,
  input  logic [NREG_BITS-1:0] wb_rd,
  output logic [FWD_BITS-1:0]  fwd
);

  // r0 is hardwired zero, so a match on it must never forward; MEM is younger than WB
  always_comb begin
    fwd = FWD_BITS'(FWD_RF);
    if (ex_src == NREG_BITS'(REG_R0))
      fwd = FWD_BITS'(FWD_RF);
    else if (ex_src == mem_rd)
      fwd = FWD_BITS'(FWD_MEM);
    else if (ex_src == wb_rd)
      fwd = FWD_BITS'(FWD_WB);
  end

endmodule

// File: rtl/dlx_interlock_ctrl.sv
// rtl/dlx_interlock_ctrl.sv - load-use stall, memory freeze and forwarding control; DLX_INTERLOCK_STATS_EN adds counters
module dlx_interlock_ctrl
  import dlx_pipe_pkg::*;
#(
  parameter int NREG_BITS = 5,
  parameter int FWD_BITS  = 2
) (
  input  logic                 CLK,
  input  logic                 MRST,
  input  logic                 ID_valid,
  input  logic [NREG_BITS-1:0] ID_RSaddr,
  input  logic [NREG_BITS-1:0] ID_RTaddr,
  input  logic [NREG_BITS-1:0] ID_RDaddr,
  input  logic                 ID_uses_rt,
  input  logic                 ID_is_load,
  input  logic                 MEM_busy,
  output logic                 Stall,
  output logic                 Bubble,
  output logic                 Freeze,
`ifdef DLX_INTERLOCK_STATS_EN
  output logic [31:0]          StallCnt,
  output logic [31:0]          FreezeCnt,
`endif
  output logic [FWD_BITS-1:0]  FwdA,
  output logic [FWD_BITS-1:0]  FwdB
);

  state_t                 state, state_nx;
  logic [NREG_BITS-1:0]   ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic                   ex_load;
  logic                   hz;

  assign hz = ID_valid & ex_load & (ex_rd != NREG_BITS'(REG_R0)) &
              ((ID_RSaddr == ex_rd) | (ID_uses_rt & (ID_RTaddr == ex_rd)));

  assign Freeze = MEM_busy;
  assign Stall  = hz | MEM_busy;
  assign Bubble = hz & ~MEM_busy;

  always_ff @(posedge CLK or posedge MRST) begin
    if (MRST) begin
      ex_rs   <= '0;
      ex_rt   <= '0;
      ex_rd   <= '0;
      ex_load <= 1'b0;
      mem_rd  <= '0;
      wb_rd   <= '0;
    end else if (!Freeze) begin
      wb_rd  <= mem_rd;
      mem_rd <= ex_rd;
      if (Bubble) begin
        ex_rs   <= '0;
        ex_rt   <= '0;
        ex_rd   <= '0;
        ex_load <= 1'b0;
      end else begin
        ex_rs   <= ID_RSaddr;
        ex_rt   <= ID_RTaddr;
        ex_rd   <= ID_valid ? ID_RDaddr : '0;
        ex_load <= ID_valid & ID_is_load;
      end
    end
  end

  always_ff @(posedge CLK or posedge MRST) begin
    if (MRST) state <= ST_RUN;
    else      state <= state_nx;
  end

  // After a bubble EX_load is clear, so LDSTALL can never chain into a second stall
  always_comb begin
    state_nx = ST_RUN;
    case (state)
      ST_RUN:     state_nx = MEM_busy ? ST_FREEZE : (hz ? ST_LDSTALL : ST_RUN);
      ST_LDSTALL: state_nx = MEM_busy ? ST_FREEZE : ST_RUN;
      ST_FREEZE:  state_nx = MEM_busy ? ST_FREEZE : ST_RUN;
      default:    state_nx = ST_RUN;
    endcase
  end

  dlx_fwd_sel #(.NREG_BITS(NREG_BITS), .FWD_BITS(FWD_BITS)) u_fwd_rs (
    .ex_src (ex_rs),
    .mem_rd (mem_rd),
    .wb_rd  (wb_rd),
    .fwd    (FwdA)
  );

  dlx_fwd_sel #(.NREG_BITS(NREG_BITS), .FWD_BITS(FWD_BITS)) u_fwd_rt (
    .ex_src (ex_rt),
    .mem_rd (mem_rd),
    .wb_rd  (wb_rd),
    .fwd    (FwdB)
  );

`ifdef DLX_INTERLOCK_STATS_EN
  always_ff @(posedge CLK or posedge MRST) begin
    if (MRST) begin
      StallCnt  <= '0;
      FreezeCnt <= '0;
    end else begin
      if (Bubble && (StallCnt != 32'hFFFF_FFFF))
        StallCnt <= StallCnt + 32'd1;
      if (Freeze && (FreezeCnt != 32'hFFFF_FFFF))
        FreezeCnt <= FreezeCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dlx_interlock_ctrl.sv
// tb/tb_dlx_interlock_ctrl.sv - self-checking bench for dlx_interlock_ctrl
module tb_dlx_interlock_ctrl;

  typedef struct packed {
    logic       st;
    logic       bu;
    logic       fr;
    logic [1:0] fa;
    logic [1:0] fb;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       ut;
    logic       ld;
    logic       busy;
    exp_t       e;
  } vec_t;

  logic       CLK = 1'b0;
  logic       MRST = 1'b1;
  logic       ID_valid = 1'b0;
  logic [4:0] ID_RSaddr = '0, ID_RTaddr = '0, ID_RDaddr = '0;
  logic       ID_uses_rt = 1'b0, ID_is_load = 1'b0, MEM_busy = 1'b0;
  logic       Stall, Bubble, Freeze;
  logic [1:0] FwdA, FwdB;
`ifdef DLX_INTERLOCK_STATS_EN
  logic [31:0] StallCnt, FreezeCnt;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t p1[$];
  vec_t p2[$];

  always #5 CLK = ~CLK;

  dlx_interlock_ctrl dut (
    .CLK        (CLK),
    .MRST       (MRST),
    .ID_valid   (ID_valid),
    .ID_RSaddr  (ID_RSaddr),
    .ID_RTaddr  (ID_RTaddr),
    .ID_RDaddr  (ID_RDaddr),
    .ID_uses_rt (ID_uses_rt),
    .ID_is_load (ID_is_load),
    .MEM_busy   (MEM_busy),
    .Stall      (Stall),
    .Bubble     (Bubble),
    .Freeze     (Freeze),
`ifdef DLX_INTERLOCK_STATS_EN
    .StallCnt   (StallCnt),
    .FreezeCnt  (FreezeCnt),
`endif
    .FwdA       (FwdA),
    .FwdB       (FwdB)
  );

  function automatic vec_t mk(input logic rst, input logic valid, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] rd, input logic ut,
                              input logic ld, input logic busy, input logic st, input logic bu,
                              input logic fr, input logic [1:0] fa, input logic [1:0] fb);
    vec_t v;
    v.rst = rst; v.valid = valid; v.rs = rs; v.rt = rt; v.rd = rd;
    v.ut = ut; v.ld = ld; v.busy = busy;
    v.e.st = st; v.e.bu = bu; v.e.fr = fr; v.e.fa = fa; v.e.fb = fb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge CLK);
    MRST       = v.rst;
    ID_valid   = v.valid;
    ID_RSaddr  = v.rs;
    ID_RTaddr  = v.rt;
    ID_RDaddr  = v.rd;
    ID_uses_rt = v.ut;
    ID_is_load = v.ld;
    MEM_busy   = v.busy;
    sb.push_back(v.e);
  endtask

  task automatic sample(input string tag);
    exp_t e;
    e = sb.pop_front();
    chk({tag, ".Stall"},  {31'd0, Stall},  {31'd0, e.st});
    chk({tag, ".Bubble"}, {31'd0, Bubble}, {31'd0, e.bu});
    chk({tag, ".Freeze"}, {31'd0, Freeze}, {31'd0, e.fr});
    chk({tag, ".FwdA"},   {30'd0, FwdA},   {30'd0, e.fa});
    chk({tag, ".FwdB"},   {30'd0, FwdB},   {30'd0, e.fb});
  endtask

  initial begin
    exp_t z;
    z = '0;
    //                rst v  rs  rt  rd  ut ld bz  st bu fr fa     fb
    p1.push_back(mk(1, 0, 0,  0,  0,  0, 0, 0,  0, 0, 0, 2'd0, 2'd0)); // reset
    p1.push_back(mk(0, 1, 1,  0,  0,  0, 1, 0,  0, 0, 0, 2'd0, 2'd0)); // LW r0
    p1.push_back(mk(0, 1, 0,  0,  6,  1, 0, 0,  0, 0, 0, 2'd0, 2'd0)); // ADD r6<-r0+r0
    p1.push_back(mk(0, 1, 0,  0,  0,  0, 0, 0,  0, 0, 0, 2'd0, 2'd0)); // ADDI r0
    p1.push_back(mk(0, 1, 1,  2,  3,  1, 0, 0,  0, 0, 0, 2'd0, 2'd0)); // ADD r3
    p1.push_back(mk(0, 1, 3,  3,  7,  1, 0, 0,  0, 0, 0, 2'd0, 2'd0)); // SUB r7<-r3-r3
    p1.push_back(mk(0, 1, 4,  5,  3,  1, 0, 0,  0, 0, 0, 2'd1, 2'd1)); // ADD r3 (SUB in EX)
    p1.push_back(mk(0, 0, 0,  0,  0,  0, 0, 0,  0, 0, 0, 2'd0, 2'd0)); // NOP
    p1.push_back(mk(0, 1, 3,  4,  1,  1, 0, 0,  0, 0, 0, 2'd0, 2'd0)); // OR r1<-r3|r4
    p1.push_back(mk(0, 0, 0,  0,  0,  0, 0, 0,  0, 0, 0, 2'd2, 2'd0)); // OR in EX, WB fwd
    p1.push_back(mk(0, 1, 0,  0,  9,  0, 0, 0,  0, 0, 0, 2'd0, 2'd0)); // ADDI r9
    p1.push_back(mk(0, 1, 0,  0,  9,  0, 0, 0,  0, 0, 0, 2'd0, 2'd0)); // ADDI r9
    p1.push_back(mk(0, 1, 1,  9,  2,  1, 0, 0,  0, 0, 0, 2'd0, 2'd0)); // ADD r2<-r1+r9
    p1.push_back(mk(0, 0, 0,  0,  0,  0, 0, 0,  0, 0, 0, 2'd0, 2'd1)); // double match
    p1.push_back(mk(0, 1, 1,  0,  5,  0, 1, 0,  0, 0, 0, 2'd0, 2'd0)); // LW r5
    p1.push_back(mk(0, 1, 5,  2,  6,  1, 0, 0,  1, 1, 0, 2'd0, 2'd0)); // ADD r6<-r5: stall
    p1.push_back(mk(0, 1, 5,  2,  6,  1, 0, 0,  0, 0, 0, 2'd0, 2'd0)); // held ADD, no stall
    p1.push_back(mk(0, 0, 0,  0,  0,  0, 0, 0,  0, 0, 0, 2'd2, 2'd0)); // ADD in EX
    p1.push_back(mk(0, 1, 6,  0,  5,  0, 1, 0,  0, 0, 0, 2'd0, 2'd0)); // LW r5<-(r6)

    p2.push_back(mk(0, 1, 0,  0,  8,  0, 1, 0,  0, 0, 0, 2'd0, 2'd0)); // LW r8
    p2.push_back(mk(0, 1, 2,  8,  1,  1, 0, 1,  1, 0, 1, 2'd0, 2'd0)); // SUB r1<-r2-r8, busy
    p2.push_back(mk(0, 1, 2,  8,  1,  1, 0, 1,  1, 0, 1, 2'd0, 2'd0));
    p2.push_back(mk(0, 1, 2,  8,  1,  1, 0, 1,  1, 0, 1, 2'd0, 2'd0));
    p2.push_back(mk(0, 1, 2,  8,  1,  1, 0, 0,  1, 1, 0, 2'd0, 2'd0)); // release: bubble
    p2.push_back(mk(0, 1, 2,  8,  1,  1, 0, 0,  0, 0, 0, 2'd0, 2'd0));
    p2.push_back(mk(0, 0, 0,  0,  0,  0, 0, 0,  0, 0, 0, 2'd0, 2'd2)); // SUB in EX
    p2.push_back(mk(0, 1, 1,  0,  4,  0, 1, 0,  0, 0, 0, 2'd0, 2'd0)); // LW r4
    p2.push_back(mk(0, 1, 1,  4,  7,  0, 0, 0,  0, 0, 0, 2'd2, 2'd0)); // rt=r4 not read
    p2.push_back(mk(0, 0, 0,  0,  0,  0, 0, 0,  0, 0, 0, 2'd0, 2'd1));

    for (int i = 0; i < p1.size(); i++) begin
      drive(p1[i]);
      #2;
      sample($sformatf("p1[%0d]", i));
    end

    // Async reset mid-cycle while a load-use hazard and WB forward are live
    drive(mk(0, 1, 5, 2, 6, 1, 0, 0, 1, 1, 0, 2'd2, 2'd0));
    #2;
    sample("pre_rst");
    #1 MRST = 1'b1;
    sb.push_back(z);
    #1;
    sample("async_rst");

    for (int i = 0; i < p2.size(); i++) begin
      drive(p2[i]);
      #2;
      sample($sformatf("p2[%0d]", i));
    end

`ifdef DLX_INTERLOCK_STATS_EN
    chk("FreezeCnt", FreezeCnt, 32'd3);
    chk("StallCnt",  StallCnt,  32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
